// File: rtl/mydp.sv
// Four-register shift/ALU datapath with sticky overflow,
// saturating load counter and a registered R2-load pulse.
module mydp (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [1:0]  sel,
   input  logic [2:0]  w,
   input  logic [2:0]  s,
   input  logic [3:0]  ce,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] y,
   output logic        ovf,
   output logic [3:0]  cnt,
   output logic        done
);

   logic [3:0][15:0] r_q, r_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [15:0] op;
   logic [22:0] sh_wide;
   logic [15:0] sh;
   logic        loss;
   logic [16:0] ext;
   logic [15:0] alu;
   logic        arith;
   logic        shift_used;

   always_comb begin
      op = 16'd0;
      unique case (sel)
         2'd0: op = {8'd0, a};
         2'd1: op = {8'd0, b};
         2'd2: op = r_q[0];
         2'd3: op = r_q[1];
      endcase
   end

   // 23 bits hold every bit a 7-place shift can push out.
   assign sh_wide = {7'd0, op} << s;
   assign sh      = sh_wide[15:0];
   assign loss    = |sh_wide[22:16];

   always_comb begin
      ext        = 17'd0;
      alu        = 16'd0;
      arith      = 1'b0;
      shift_used = 1'b1;
      unique case (w)
         3'd0: alu = sh;
         3'd1: begin
            ext   = {1'b0, r_q[3]} + {1'b0, sh};
            alu   = ext[15:0];
            arith = ext[16];
         end
         3'd2: begin
            ext   = {1'b0, r_q[3]} - {1'b0, sh};
            alu   = ext[15:0];
            arith = ext[16];
         end
         3'd3: alu = r_q[3] & sh;
         3'd4: begin
            ext        = {1'b0, r_q[0]} + {1'b0, r_q[1]};
            alu        = ext[15:0];
            arith      = ext[16];
            shift_used = 1'b0;
         end
         3'd5: begin
            ext        = {1'b0, r_q[0]} - {1'b0, r_q[1]};
            alu        = ext[15:0];
            arith      = ext[16];
            shift_used = 1'b0;
         end
         3'd6: alu = r_q[3] | sh;
         3'd7: alu = r_q[3] ^ sh;
      endcase
   end

   always_comb begin
      r_d    = r_q;
      ovf_d  = ovf_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (clr) begin
         r_d   = '0;
         ovf_d = 1'b0;
         cnt_d = 4'd0;
      end else if (|ce) begin
         for (int k = 0; k < 4; k++) begin
            if (ce[k]) r_d[k] = alu;
         end
         ovf_d  = ovf_q | arith | (loss & shift_used);
         cnt_d  = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
         done_d = ce[2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= 4'd0;
         done_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign y    = r_q[2];
   assign ovf  = ovf_q;
   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: tb/tb_mydp.sv
// Directed scoreboard bench for mydp: stimulus queues
// hand-computed post-edge state, a monitor pops and compares.
module tb_mydp;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic [1:0]  sel;
   logic [2:0]  w, s;
   logic [3:0]  ce;
   logic [7:0]  a, b;
   logic [15:0] y;
   logic        ovf, done;
   logic [3:0]  cnt;

   typedef struct {
      logic [15:0] y;
      logic        ovf;
      logic [3:0]  cnt;
      logic        done;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   mydp dut (
      .clk(clk), .rst(rst), .clr(clr), .sel(sel), .w(w), .s(s),
      .ce(ce), .a(a), .b(b), .y(y), .ovf(ovf), .cnt(cnt), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks += 4;
         if (y !== e.y) begin
            errors++;
            $display("FAIL %s y got %h want %h", e.nm, y, e.y);
         end
         if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s ovf got %b want %b", e.nm, ovf, e.ovf);
         end
         if (cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s cnt got %0d want %0d", e.nm, cnt, e.cnt);
         end
         if (done !== e.done) begin
            errors++;
            $display("FAIL %s done got %b want %b", e.nm, done, e.done);
         end
      end
   end

   task automatic step(
      input logic r, input logic c, input logic [1:0] sl,
      input logic [2:0] ww, input logic [2:0] ss,
      input logic [3:0] e, input logic [7:0] aa,
      input logic [15:0] ey, input logic eo,
      input logic [3:0] ec, input logic ed, input string nm);
      exp_t x;
      rst = r; clr = c; sel = sl; w = ww; s = ss; ce = e; a = aa;
      @(posedge clk);
      #1;
      x.y = ey; x.ovf = eo; x.cnt = ec; x.done = ed; x.nm = nm;
      exp_q.push_back(x);
   endtask

   task automatic idle(input logic [15:0] ey, input logic eo,
                       input logic [3:0] ec, input string nm);
      step(0, 0, 0, 0, 0, 4'h0, 8'h00, ey, eo, ec, 1'b0, nm);
   endtask

   initial begin
      int c;
      rst = 1; clr = 0; sel = 0; w = 0; s = 0; ce = 0; a = 0; b = 8'h05;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, "reset");

      // Basic sequence with a=3, b=5
      step(0, 1, 0, 0, 0, 4'h0, 8'h03, 16'h0000, 0, 0, 0, "clr");
      step(0, 0, 0, 0, 2, 4'h1, 8'h03, 16'h0000, 0, 1, 0, "r0_ld");
      step(0, 0, 0, 0, 2, 4'h8, 8'h03, 16'h0000, 0, 2, 0, "r3_ld_a");
      step(0, 0, 1, 0, 1, 4'h2, 8'h03, 16'h0000, 0, 3, 0, "r1_ld");
      step(0, 0, 1, 0, 1, 4'h8, 8'h03, 16'h0000, 0, 4, 0, "r3_ld_b");
      step(0, 0, 0, 4, 0, 4'h4, 8'h03, 16'd22,   0, 5, 1, "add_r0r1");
      idle(16'd22, 0, 5, "done_drop");
      step(0, 0, 2, 0, 0, 4'h4, 8'h03, 16'd12,   0, 6, 1, "rd_r0");
      step(0, 0, 3, 0, 0, 4'h4, 8'h03, 16'd10,   0, 7, 1, "rd_r1");
      step(0, 0, 0, 4, 0, 4'h4, 8'h03, 16'd22,   0, 8, 1, "add_again");
      step(1, 1, 0, 4, 0, 4'h4, 8'h03, 16'h0000, 0, 0, 0, "rst_mid");
      step(0, 0, 0, 0, 0, 4'h4, 8'h03, 16'h0003, 0, 1, 1, "after_rst");

      // Carry out of R3 + sh
      step(0, 1, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, "clr2");
      step(0, 0, 0, 0, 7, 4'h8, 8'hFF, 16'h0000, 0, 1, 0, "r3_7f80");
      step(0, 0, 0, 1, 7, 4'h8, 8'hFF, 16'h0000, 0, 2, 0, "r3_ff00");
      step(0, 0, 0, 6, 0, 4'h8, 8'hF0, 16'h0000, 0, 3, 0, "r3_fff0");
      step(0, 0, 0, 6, 0, 4'h4, 8'h00, 16'hFFF0, 0, 4, 1, "rd_fff0");
      step(0, 0, 0, 1, 0, 4'h8, 8'h20, 16'hFFF0, 1, 5, 0, "carry");
      step(0, 0, 0, 6, 0, 4'h4, 8'h00, 16'h0010, 1, 6, 1, "rd_0010");
      for (int i = 0; i < 10; i++) idle(16'h0010, 1, 6, "ovf_sticky");

      // Shift loss from a register source; ce=0 ignores overflow
      step(0, 1, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, "clr3");
      step(0, 0, 0, 2, 7, 4'h0, 8'hFF, 16'h0000, 0, 0, 0, "ce0_borrow");
      step(0, 0, 0, 0, 7, 4'h8, 8'h80, 16'h0000, 0, 1, 0, "r3_4000");
      step(0, 0, 0, 1, 7, 4'h8, 8'h80, 16'h0000, 0, 2, 0, "r3_8000");
      step(0, 0, 0, 6, 0, 4'h1, 8'h01, 16'h0000, 0, 3, 0, "r0_8001");
      step(0, 0, 2, 0, 1, 4'h2, 8'h00, 16'h0000, 1, 4, 0, "shift_loss");
      step(0, 0, 3, 0, 0, 4'h4, 8'h00, 16'h0002, 1, 5, 1, "rd_r1_2");

      // clr beats ce in the same cycle
      step(0, 1, 0, 0, 0, 4'hF, 8'h55, 16'h0000, 0, 0, 0, "clr_ce");
      idle(16'h0000, 0, 0, "clr_hold");
      step(0, 0, 0, 4, 0, 4'h4, 8'h00, 16'h0000, 0, 1, 1, "r0r1_zero");
      step(0, 0, 0, 6, 0, 4'h4, 8'h00, 16'h0000, 0, 2, 1, "r3_zero");

      // Multi-load and counter saturation
      step(0, 1, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, "clr4");
      step(0, 0, 0, 0, 1, 4'h5, 8'h07, 16'd14,   0, 1, 1, "ld_r0r2");
      step(0, 0, 2, 0, 0, 4'h4, 8'h07, 16'd14,   0, 2, 1, "r0_eq_r2");
      for (int i = 0; i < 20; i++) begin
         c = (i + 3 > 15) ? 15 : i + 3;
         step(0, 0, 0, 0, 1, 4'h1, 8'h07, 16'd14, 0, 4'(c), 0, "cnt_sat");
      end
      idle(16'd14, 0, 15, "cnt_hold");

      // Subtract, borrow, xor, and
      step(0, 1, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, "clr5");
      step(0, 0, 0, 0, 0, 4'h1, 8'h05, 16'h0000, 0, 1, 0, "r0_5");
      step(0, 0, 0, 0, 0, 4'h2, 8'h03, 16'h0000, 0, 2, 0, "r1_3");
      step(0, 0, 0, 5, 0, 4'h4, 8'h00, 16'h0002, 0, 3, 1, "sub_ok");
      step(0, 0, 0, 0, 0, 4'h1, 8'h01, 16'h0002, 0, 4, 0, "r0_1");
      step(0, 0, 0, 5, 0, 4'h4, 8'h00, 16'hFFFE, 1, 5, 1, "sub_borrow");
      step(0, 0, 0, 0, 0, 4'h8, 8'hAA, 16'hFFFE, 1, 6, 0, "r3_aa");
      step(0, 0, 0, 7, 4, 4'h4, 8'h0F, 16'h005A, 1, 7, 1, "xor");
      step(0, 0, 0, 3, 0, 4'h4, 8'hFF, 16'h00AA, 1, 8, 1, "and");
      idle(16'h00AA, 1, 8, "final_idle");

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mydp.md
MYDP -- requirements
Module: mydp

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port clr, input, 1, synchronous datapath clear.
REQ-004 SHALL have port sel, input, 2, operand select: 0=a, 1=b, 2=R0, 3=R1.
REQ-005 SHALL have port w, input, 3, ALU op select.
REQ-006 SHALL have port s, input, 3, left-shift amount 0..7.
REQ-007 SHALL have port ce, input, 4, register load enables; bit k loads Rk.
REQ-008 SHALL have port a, input, 8, unsigned operand A.
REQ-009 SHALL have port b, input, 8, unsigned operand B.
REQ-010 SHALL have port y, output, 16, always equal to R2.
REQ-011 SHALL have port ovf, output, 1, sticky overflow flag.
REQ-012 SHALL have port cnt, output, 4, number of load cycles since clear, saturating.
REQ-013 SHALL have port done, output, 1, registered one-cycle pulse after an R2 load.

Function
REQ-014 SHALL hold four 16-bit registers R0..R3, zero-extending a and b to 16 bits.
REQ-015 SHALL form operand op from sel, then sh = (op << s) truncated to 16 bits.
REQ-016 SHALL set shift-loss when any bit shifted past bit 15 is 1; a/b sources never lose bits.
REQ-017 SHALL compute alu per w: 0 sh; 1 R3+sh; 2 R3-sh; 3 R3&sh; 4 R0+R1; 5 R0-R1; 6 R3|sh; 7 R3^sh.
REQ-018 SHALL, for w=4 and w=5, ignore sel and s (no shift-loss contribution).
REQ-019 SHALL give arithmetic results modulo 2^16; carry out of bit 15 (add) or borrow (sub) is an arith-overflow.
REQ-020 SHALL, on a clock edge with clr=0 and ce!=0, load alu into every Rk whose ce[k]=1, all in the same cycle.
REQ-021 SHALL read operands from pre-edge register values, so that R3 += sh with ce[3]=1 uses the old R3.
REQ-022 SHALL set ovf on a load edge when shift-loss or arith-overflow occurs, and hold it until clr or rst.
REQ-023 SHALL ignore overflow conditions on edges with ce=0.
REQ-024 SHALL increment cnt on each load edge, holding at 15 when already 15.
REQ-025 SHALL drive done=1 for exactly the cycle following a load edge with ce[2]=1, and 0 otherwise.
REQ-026 SHALL, on clr=1, zero R0..R3, ovf, cnt and done at the edge, with clr taking priority over ce in the same cycle.
REQ-027 SHALL hold all registers when clr=0 and ce=0.
REQ-028 SHALL have no combinational path from control inputs to y, ovf, cnt or done.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, zero R0..R3, y, ovf, cnt and done, with priority over clr and ce.
REQ-030 SHALL, when rst asserts mid-sequence, discard partial results, and after release SHALL accept the next control word immediately.

Verification
REQ-031 SHALL be checked with a=3, b=5 and control sequence (clr), (sel0 s2 ce1), (sel0 s2 w0 ce8), (sel1 s1 ce2), (sel1 s1 ce8), (w4 ce4) -> R0=12, R1=10, y=22, done pulse one cycle after, cnt=5, ovf=0.
REQ-032 SHALL be checked with R3=0xFFF0, a=0x20, sel0 s0 w1 ce8 -> R3=0x0010, ovf=1, and ovf still 1 after ten idle cycles.
REQ-033 SHALL be checked with R0=0x8001, sel2 s1 w0 ce2 -> R1=0x0002, ovf=1 (shift loss).
REQ-034 SHALL be checked with clr=1 and ce=4'hF in the same cycle -> all registers 0, cnt=0, done=0 next cycle.
REQ-035 SHALL be checked with 20 consecutive load cycles -> cnt saturates at 15; ce=4'b0101 loads R0 and R2 with an identical value.
REQ-036 SHALL be checked with rst asserted between the w4/ce4 step and the following cycle -> y=0, done=0, ovf=0, cnt=0.
